div_cluster: RTL and testbench

Multi-lane iterative integer divider serving the fixed-point divide issue path. It sits behind a reservation station and takes fully resolved operands over a ready/valid interface. Instructions are dispatched to one of NUM_UNITS radix-2 restoring divide lanes, and completed results return tagged with their RS id, possibly out of order. Compared with a single-unit divide path, it adds parallel lanes, parametrised width, an early exit for exceptional cases, and fair output arbitration.

---
 rtl/div_cluster.sv | 253 +++++++++++++++++++++++++
 tb/tb_div_cluster.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_cluster.sv
`default_nettype none
// ============================================================================
// Module      : div_cluster
// Description : Multi-lane radix-2 restoring integer divider. Operands are
//               dispatched to the lowest-index idle lane; finished lanes are
//               drained through a round-robin, grant-locking output port.
// Revision    : 1.0 - initial release
// ============================================================================
module div_cluster #(
    parameter int RS_ID_WIDTH = 5,
    parameter int NUM_UNITS   = 2,
    parameter int WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [WIDTH-1:0]       op1,
    input  logic [WIDTH-1:0]       op2,
    input  logic                   xer_so_in,
    input  logic                   signed_op,
    input  logic                   oe,
    input  logic                   rc,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [WIDTH-1:0]       result,
    output logic                   ov_out,
    output logic                   so_out,
    output logic [3:0]             cr0_out,
    output logic                   xer_write,
    output logic                   cr0_write
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lane_state_e;

    // Per-lane registered state
    lane_state_e            state_q    [NUM_UNITS];
    logic [CNT_W-1:0]       cnt_q      [NUM_UNITS];
    logic [WIDTH-1:0]       rem_q      [NUM_UNITS];
    logic [WIDTH-1:0]       quo_q      [NUM_UNITS];
    logic [WIDTH-1:0]       dvsr_q     [NUM_UNITS];
    logic                   neg_q      [NUM_UNITS];
    logic                   exc_q      [NUM_UNITS];
    logic [RS_ID_WIDTH-1:0] id_q       [NUM_UNITS];
    logic [4:0]             addr_q     [NUM_UNITS];
    logic                   so_in_q    [NUM_UNITS];
    logic                   oe_q       [NUM_UNITS];
    logic                   rc_q       [NUM_UNITS];

    // Per-lane next-iteration values and completed-result views
    logic [WIDTH-1:0]       rem_d      [NUM_UNITS];
    logic [WIDTH-1:0]       quo_d      [NUM_UNITS];
    logic [WIDTH-1:0]       res_w      [NUM_UNITS];
    logic                   ov_w       [NUM_UNITS];
    logic                   so_w       [NUM_UNITS];
    logic [3:0]             cr0_w      [NUM_UNITS];
    logic [NUM_UNITS-1:0]   idle_w;
    logic [NUM_UNITS-1:0]   done_w;

    // Arbitration state
    logic [PTR_W-1:0]       rr_q;
    logic                   lock_q;
    logic [PTR_W-1:0]       gnt_q;

    logic [PTR_W-1:0]       alloc_idx;
    logic                   alloc_any;
    logic [PTR_W-1:0]       rr_idx;
    logic                   rr_any;
    logic [PTR_W-1:0]       sel;
    logic                   out_fire;

    // Operand preparation for the incoming op
    logic                   op1_neg;
    logic                   op2_neg;
    logic [WIDTH-1:0]       op1_mag;
    logic [WIDTH-1:0]       op2_mag;
    logic                   op_exc;
    logic                   op_neg;

    assign op1_neg = signed_op & op1[WIDTH-1];
    assign op2_neg = signed_op & op2[WIDTH-1];
    assign op1_mag = op1_neg ? (~op1 + 1'b1) : op1;
    assign op2_mag = op2_neg ? (~op2 + 1'b1) : op2;
    assign op_neg  = op1_neg ^ op2_neg;
    // Divide-by-zero and the single signed overflow case bypass the core
    assign op_exc  = (op2 == '0) ||
                     (signed_op && (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1));

    generate
        for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
            logic [WIDTH:0] shift_w;
            logic [WIDTH:0] diff_w;
            logic           ge_w;

            // Shift the next dividend bit into the partial remainder and trial-subtract
            assign shift_w  = {rem_q[i], quo_q[i][WIDTH-1]};
            assign diff_w   = shift_w - {1'b0, dvsr_q[i]};
            assign ge_w     = (shift_w >= {1'b0, dvsr_q[i]});
            assign rem_d[i] = ge_w ? diff_w[WIDTH-1:0] : shift_w[WIDTH-1:0];
            assign quo_d[i] = {quo_q[i][WIDTH-2:0], ge_w};

            // Final result and status flags seen while the lane sits in DONE
            assign res_w[i] = exc_q[i] ? '0 : (neg_q[i] ? (~quo_q[i] + 1'b1) : quo_q[i]);
            assign ov_w[i]  = exc_q[i] & oe_q[i];
            assign so_w[i]  = so_in_q[i] | ov_w[i];
            assign cr0_w[i] = {res_w[i][WIDTH-1],
                               ~res_w[i][WIDTH-1] & (|res_w[i]),
                               ~(|res_w[i]),
                               so_w[i]};

            assign idle_w[i] = (state_q[i] == ST_IDLE);
            assign done_w[i] = (state_q[i] == ST_DONE);
        end
    endgenerate

    // Lowest-index idle lane receives the next op; depends on lane state only
    always_comb begin
        alloc_idx = '0;
        alloc_any = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (idle_w[i]) begin
                alloc_any = 1'b1;
                alloc_idx = PTR_W'(i);
            end
        end
    end

    assign input_ready = alloc_any;

    // Round-robin search for the first DONE lane at or after the pointer
    always_comb begin
        int j;
        j      = 0;
        rr_idx = '0;
        rr_any = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_UNITS) begin
                j = j - NUM_UNITS;
            end
            if (!rr_any && done_w[j]) begin
                rr_any = 1'b1;
                rr_idx = PTR_W'(j);
            end
        end
    end

    // A presented result keeps its grant until it is accepted
    assign sel          = lock_q ? gnt_q : rr_idx;
    assign output_valid = lock_q | rr_any;
    assign out_fire     = output_valid & output_ready;

    // Output mux; data outputs read zero when nothing is presented
    always_comb begin
        rs_id_out           = '0;
        result_reg_addr_out = '0;
        result              = '0;
        ov_out              = 1'b0;
        so_out              = 1'b0;
        cr0_out             = '0;
        xer_write           = 1'b0;
        cr0_write           = 1'b0;
        if (output_valid) begin
            rs_id_out           = id_q[sel];
            result_reg_addr_out = addr_q[sel];
            result              = res_w[sel];
            ov_out              = ov_w[sel];
            so_out              = so_w[sel];
            cr0_out             = cr0_w[sel];
            xer_write           = oe_q[sel];
            cr0_write           = rc_q[sel];
        end
    end

    // Lane FSMs (capture, iterate, drain) and output arbitration state
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                rem_q[i]   <= '0;
                quo_q[i]   <= '0;
                dvsr_q[i]  <= '0;
                neg_q[i]   <= 1'b0;
                exc_q[i]   <= 1'b0;
                id_q[i]    <= '0;
                addr_q[i]  <= '0;
                so_in_q[i] <= 1'b0;
                oe_q[i]    <= 1'b0;
                rc_q[i]    <= 1'b0;
            end
            rr_q   <= '0;
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (input_valid && alloc_any && (alloc_idx == PTR_W'(i))) begin
                            cnt_q[i]   <= '0;
                            rem_q[i]   <= '0;
                            quo_q[i]   <= op1_mag;
                            dvsr_q[i]  <= op2_mag;
                            neg_q[i]   <= op_neg;
                            exc_q[i]   <= op_exc;
                            id_q[i]    <= rs_id_in;
                            addr_q[i]  <= result_reg_addr_in;
                            so_in_q[i] <= xer_so_in;
                            oe_q[i]    <= oe;
                            rc_q[i]    <= rc;
                            state_q[i] <= op_exc ? ST_DONE : ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        rem_q[i] <= rem_d[i];
                        quo_q[i] <= quo_d[i];
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                        if (cnt_q[i] == CNT_W'(WIDTH - 1)) begin
                            state_q[i] <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (out_fire && (sel == PTR_W'(i))) begin
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end

            if (out_fire) begin
                lock_q <= 1'b0;
                rr_q   <= (sel == PTR_W'(NUM_UNITS - 1)) ? '0 : (sel + 1'b1);
            end else if (output_valid) begin
                lock_q <= 1'b1;
                gnt_q  <= sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_cluster.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_cluster
// Description : Self-checking bench for div_cluster with a behavioural
//               arithmetic reference model and per-id scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_cluster;

    localparam int W   = 32;
    localparam int IDW = 5;
    localparam int NU  = 2;
    localparam int PKW = W + 13;

    logic           clk;
    logic           rst;
    logic           input_valid;
    logic           input_ready;
    logic [IDW-1:0] rs_id_in;
    logic [4:0]     result_reg_addr_in;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           xer_so_in;
    logic           signed_op;
    logic           oe;
    logic           rc;
    logic           output_valid;
    logic           output_ready;
    logic [IDW-1:0] rs_id_out;
    logic [4:0]     result_reg_addr_out;
    logic [W-1:0]   result;
    logic           ov_out;
    logic           so_out;
    logic [3:0]     cr0_out;
    logic           xer_write;
    logic           cr0_write;

    int checks_total;
    int checks_passed;

    logic [W-1:0] e_res  [32];
    logic         e_ov   [32];
    logic         e_so   [32];
    logic [3:0]   e_cr   [32];
    logic [4:0]   e_addr [32];
    logic         e_oe   [32];
    logic         e_rc   [32];
    bit           pend   [32];

    div_cluster #(
        .RS_ID_WIDTH (IDW),
        .NUM_UNITS   (NU),
        .WIDTH       (W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .rs_id_in            (rs_id_in),
        .result_reg_addr_in  (result_reg_addr_in),
        .op1                 (op1),
        .op2                 (op2),
        .xer_so_in           (xer_so_in),
        .signed_op           (signed_op),
        .oe                  (oe),
        .rc                  (rc),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .rs_id_out           (rs_id_out),
        .result_reg_addr_out (result_reg_addr_out),
        .result              (result),
        .ov_out              (ov_out),
        .so_out              (so_out),
        .cr0_out             (cr0_out),
        .xer_write           (xer_write),
        .cr0_write           (cr0_write)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division plus the architectural flag rules
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input logic o, input logic x,
                                  output logic [W-1:0] q, output logic ovv,
                                  output logic sov, output logic [3:0] cr);
        logic exc;
        exc = (b == '0) || (s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
        if (exc) begin
            q   = '0;
            ovv = o;
        end else begin
            ovv = 1'b0;
            if (s) q = W'($signed(a) / $signed(b));
            else   q = a / b;
        end
        sov = x | ovv;
        cr  = {($signed(q) < 0), ($signed(q) > 0), (q == '0), sov};
    endfunction

    function automatic logic [PKW-1:0] exp_pack(input int id);
        return {e_res[id], e_ov[id], e_so[id], e_cr[id], e_addr[id], e_oe[id], e_rc[id]};
    endfunction

    function automatic logic [PKW-1:0] obs_pack();
        return {result, ov_out, so_out, cr0_out, result_reg_addr_out, xer_write, cr0_write};
    endfunction

    task automatic load_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit s, input bit o, input bit r, input bit x);
        logic [W-1:0] q;
        logic         v;
        logic         so;
        logic [3:0]   cr;
        logic [4:0]   ad;
        ad = 5'($urandom);
        model(a, b, s, o, x, q, v, so, cr);
        e_res[id]  = q;
        e_ov[id]   = v;
        e_so[id]   = so;
        e_cr[id]   = cr;
        e_addr[id] = ad;
        e_oe[id]   = o;
        e_rc[id]   = r;
        pend[id]   = 1'b1;
        rs_id_in           = IDW'(id);
        result_reg_addr_in = ad;
        op1                = a;
        op2                = b;
        signed_op          = s;
        oe                 = o;
        rc                 = r;
        xer_so_in          = x;
        input_valid        = 1'b1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Offer an op until it is captured; returns after the capture edge
    task automatic send_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit s, input bit o, input bit r, input bit x, output bit ok);
        load_op(id, a, b, s, o, r, x);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (input_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        input_valid = 1'b0;
    endtask

    // Latency in cycles from the accept cycle to the first cycle with output_valid
    task automatic wait_valid(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            lat = n + 1;
            if (output_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks_total++;
        if (input_ready !== 1'b1) $display("FAIL reset_input_ready: got %b expected 1", input_ready);
        else checks_passed++;
        checks_total++;
        if (output_valid !== 1'b0) $display("FAIL reset_output_valid: got %b expected 0", output_valid);
        else checks_passed++;
        checks_total++;
        if (obs_pack() !== '0 || rs_id_out !== '0)
            $display("FAIL reset_data_outputs: got %h/%h expected 0", obs_pack(), rs_id_out);
        else checks_passed++;
    endtask

    task automatic test_unsigned();
        bit ok;
        int lat;
        do_reset();
        send_op(3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, ok);
        wait_valid(lat, ok);
        checks_total++;
        if (!ok || lat != 33) $display("FAIL unsigned_latency: got %0d (ok=%0b) expected 33", lat, ok);
        else checks_passed++;
        checks_total++;
        if (rs_id_out !== 5'd3 || result !== 32'd14 || cr0_out !== 4'b0100)
            $display("FAIL unsigned_result: got id %0d res %0d cr0 %b expected id 3 res 14 cr0 0100",
                     rs_id_out, result, cr0_out);
        else checks_passed++;
        checks_total++;
        if (obs_pack() !== exp_pack(3)) $display("FAIL unsigned_fields: got %h expected %h", obs_pack(), exp_pack(3));
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        bit ok;
        int lat;
        do_reset();
        send_op(6, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, ok);
        wait_valid(lat, ok);
        checks_total++;
        if (!ok || rs_id_out !== 5'd6 || result !== 32'hFFFF_FFF2 || cr0_out !== 4'b1000)
            $display("FAIL signed_result: got id %0d res %h cr0 %b expected id 6 res fffffff2 cr0 1000",
                     rs_id_out, result, cr0_out);
        else checks_passed++;
        checks_total++;
        if (obs_pack() !== exp_pack(6)) $display("FAIL signed_fields: got %h expected %h", obs_pack(), exp_pack(6));
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_exceptions();
        bit ok;
        int lat;
        logic [W-1:0] a_tab [2];
        logic [W-1:0] b_tab [2];
        bit           s_tab [2];
        a_tab[0] = 32'd123;       b_tab[0] = 32'd0;         s_tab[0] = 1'b0;
        a_tab[1] = 32'h8000_0000; b_tab[1] = 32'hFFFF_FFFF; s_tab[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            send_op(8 + t, a_tab[t], b_tab[t], s_tab[t], 1'b1, 1'b1, 1'b0, ok);
            wait_valid(lat, ok);
            checks_total++;
            if (!ok || lat != 1) $display("FAIL exc%0d_latency: got %0d expected 1", t, lat);
            else checks_passed++;
            checks_total++;
            if (result !== '0 || ov_out !== 1'b1 || so_out !== 1'b1 || cr0_out !== 4'b0011)
                $display("FAIL exc%0d_flags: got res %h ov %b so %b cr0 %b expected 0 1 1 0011",
                         t, result, ov_out, so_out, cr0_out);
            else checks_passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        int acc_cyc [3];
        int n_acc;
        int low;
        int got [$];
        bit take;
        n_acc = 0;
        low   = 0;
        do_reset();
        load_op(3, $urandom, W'($urandom_range(1, 1000)), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            take = 1'b0;
            @(negedge clk);
            if (n_acc < 3) begin
                if (input_ready) begin
                    take = 1'b1;
                    acc_cyc[n_acc] = cyc;
                end else if (n_acc == 2) begin
                    low++;
                end
            end
            if (output_valid && output_ready) begin
                got.push_back(int'(rs_id_out));
                checks_total++;
                if (obs_pack() !== exp_pack(int'(rs_id_out)))
                    $display("FAIL sat_result_id%0d: got %h expected %h", rs_id_out, obs_pack(), exp_pack(int'(rs_id_out)));
                else checks_passed++;
            end
            @(posedge clk); #1;
            if (take) begin
                n_acc++;
                if (n_acc < 3) load_op(3 + n_acc, $urandom, W'($urandom_range(1, 1000)), 1'b0, 1'b0, 1'b0, 1'b0);
                else input_valid = 1'b0;
            end
            if (got.size() == 3) break;
        end
        checks_total++;
        if (n_acc != 3 || got.size() != 3) begin
            $display("FAIL sat_timeout: got %0d accepts %0d results expected 3 3", n_acc, got.size());
        end else begin
            checks_passed++;
            checks_total++;
            if (acc_cyc[1] - acc_cyc[0] != 1 || acc_cyc[2] - acc_cyc[0] != 34)
                $display("FAIL sat_accept_spacing: got %0d,%0d expected 1,34",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[0]);
            else checks_passed++;
            checks_total++;
            if (low != 32) $display("FAIL sat_ready_low: got %0d cycles expected 32", low);
            else checks_passed++;
            checks_total++;
            if (got[0] != 3 || got[1] != 4 || got[2] != 5)
                $display("FAIL sat_order: got %0d %0d %0d expected 3 4 5", got[0], got[1], got[2]);
            else checks_passed++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int ids [$];
        int cyc_of [$];
        do_reset();
        output_ready = 1'b0;
        send_op(10, 32'd55, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, ok);
        send_op(11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, ok);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks_total++;
            if (output_valid !== 1'b1 || rs_id_out !== 5'd10 || obs_pack() !== exp_pack(10))
                $display("FAIL stall_stable_c%0d: got v %b id %0d %h expected v 1 id 10 %h",
                         c, output_valid, rs_id_out, obs_pack(), exp_pack(10));
            else checks_passed++;
            @(posedge clk); #1;
        end
        output_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (output_valid) begin
                ids.push_back(int'(rs_id_out));
                cyc_of.push_back(c);
                checks_total++;
                if (obs_pack() !== exp_pack(int'(rs_id_out)))
                    $display("FAIL release_result_id%0d: got %h expected %h", rs_id_out, obs_pack(), exp_pack(int'(rs_id_out)));
                else checks_passed++;
            end
            @(posedge clk); #1;
        end
        checks_total++;
        if (ids.size() != 2 || ids[0] != 10 || ids[1] != 11 || cyc_of[1] - cyc_of[0] != 1)
            $display("FAIL release_order: got %0d results first %0d second %0d expected 2 results 10 then 11 consecutive",
                     ids.size(), ids[0], ids[1]);
        else checks_passed++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int lat;
        int ids [$];
        do_reset();
        send_op(12, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        wait_valid(lat, ok);
        @(posedge clk); #1;
        // Lane 0 just handed off, so the pointer now favours lane 1
        send_op(13, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, ok);
        repeat (31) begin
            @(posedge clk); #1;
        end
        send_op(14, 32'd77, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, ok);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (output_valid) ids.push_back(int'(rs_id_out));
            @(posedge clk); #1;
        end
        checks_total++;
        if (ids.size() != 2 || ids[0] != 14 || ids[1] != 13)
            $display("FAIL rr_order: got %0d results %0d %0d expected 14 then 13", ids.size(), ids[0], ids[1]);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        int seen;
        seen = 0;
        do_reset();
        send_op(20, 32'd5000, 32'd13, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks_total++;
        if (input_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", input_ready);
        else checks_passed++;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (output_valid) seen++;
            @(posedge clk); #1;
        end
        checks_total++;
        if (seen != 0) $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen);
        else checks_passed++;
        send_op(21, 32'hDEAD_BEEF, 32'd1234, 1'b0, 1'b1, 1'b1, 1'b1, ok);
        wait_valid(lat, ok);
        checks_total++;
        if (!ok || lat != 33 || rs_id_out !== 5'd21 || obs_pack() !== exp_pack(21))
            $display("FAIL midrst_next_op: got lat %0d id %0d %h expected 33 21 %h",
                     lat, rs_id_out, obs_pack(), exp_pack(21));
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        localparam int NR = 40;
        int sent;
        int recv;
        bit hold_chk;
        int hold_id;
        bit acc;
        int id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit s;
        int kind;
        sent     = 0;
        recv     = 0;
        hold_chk = 1'b0;
        hold_id  = 0;
        do_reset();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 20000 && recv < NR; cyc++) begin
            if (!input_valid && sent < NR && ($urandom % 3) != 0) begin
                id   = sent % 32;
                kind = int'($urandom % 8);
                a    = $urandom;
                s    = 1'($urandom);
                if (kind == 0)      b = '0;
                else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                else if (kind == 2) b = W'($urandom_range(1, 15));
                else                b = $urandom;
                load_op(id, a, b, s, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            output_ready = (($urandom % 4) != 0);
            @(negedge clk);
            if (hold_chk) begin
                checks_total++;
                if (output_valid !== 1'b1 || int'(rs_id_out) != hold_id || obs_pack() !== exp_pack(hold_id))
                    $display("FAIL rand_stall_id%0d: got v %b id %0d %h expected %h",
                             hold_id, output_valid, rs_id_out, obs_pack(), exp_pack(hold_id));
                else checks_passed++;
            end
            hold_chk = 1'b0;
            if (output_valid === 1'b1) begin
                if (output_ready) begin
                    checks_total++;
                    if (!pend[int'(rs_id_out)] || obs_pack() !== exp_pack(int'(rs_id_out)))
                        $display("FAIL rand_result_id%0d: got %h pending %0b expected %h pending 1",
                                 rs_id_out, obs_pack(), pend[int'(rs_id_out)], exp_pack(int'(rs_id_out)));
                    else checks_passed++;
                    pend[int'(rs_id_out)] = 1'b0;
                    recv++;
                end else begin
                    hold_chk = 1'b1;
                    hold_id  = int'(rs_id_out);
                end
            end
            acc = input_valid && input_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                input_valid = 1'b0;
            end
        end
        checks_total++;
        if (recv != NR) $display("FAIL rand_complete: got %0d results expected %0d", recv, NR);
        else checks_passed++;
    endtask

    initial begin
        checks_total       = 0;
        checks_passed      = 0;
        clk                = 1'b0;
        rst                = 1'b0;
        input_valid        = 1'b0;
        output_ready       = 1'b1;
        rs_id_in           = '0;
        result_reg_addr_in = '0;
        op1                = '0;
        op2                = '0;
        xer_so_in          = 1'b0;
        signed_op          = 1'b0;
        oe                 = 1'b0;
        rc                 = 1'b0;
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_unsigned();
        test_signed();
        test_exceptions();
        test_saturation();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
